// File: rtl/cnn_sdiv_25s_14s_seq.sv
// rtl/cnn_sdiv_25s_14s_seq.sv - sequential 25s/14s signed divider, restoring, one quotient bit per cycle
// Optional feature macro: CNN_SDIV_DBZ_FLAG_EN adds the dbz (divide-by-zero) output.
module cnn_sdiv_25s_14s_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int          din0_WIDTH = 25,
  parameter int          din1_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [din0_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem
`ifdef CNN_SDIV_DBZ_FLAG_EN
  ,
  output logic                  dbz
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [25:0] dividend_abs;
  logic [13:0] divisor_abs;
  logic        sign0;
  logic        sign1;
  logic        div_zero;
  logic [24:0] quo;
  logic [13:0] part;

  logic [25:0] din0_sext;
  logic [25:0] din0_abs;
  logic [13:0] din1_abs;
  logic [14:0] part_sh;
  logic        step_ge;
  logic [13:0] part_sub;
  logic        capture;
  logic        unused_id;

  // ID is only an instance tag
  assign unused_id = ^ID;

  // Magnitudes of the incoming operands; 26 bits so that |-2^24| is representable
  assign din0_sext = {din0[24], din0};
  assign din0_abs  = din0[24] ? (26'd0 - din0_sext) : din0_sext;
  assign din1_abs  = din1[13] ? (14'd0 - din1) : din1;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so the difference fits 14 bits.
  assign part_sh  = {part, dividend_abs[cnt]};
  assign step_ge  = (part_sh >= {1'b0, divisor_abs});
  assign part_sub = part_sh[13:0] - divisor_abs;

  // Handshake decode; reset wins over a start in the same cycle
  assign capture  = (state == S_IDLE) && ap_start && !ap_rst;
  assign ap_ready = capture;
  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);

`ifdef CNN_SDIV_DBZ_FLAG_EN
  // Flag a zero divisor alongside the result
  assign dbz = (state == S_DONE) && div_zero;
`endif

  // Control FSM, operand capture and the iterative quotient/remainder datapath
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= S_IDLE;
      cnt          <= 5'd0;
      dividend_abs <= 26'd0;
      divisor_abs  <= 14'd0;
      sign0        <= 1'b0;
      sign1        <= 1'b0;
      div_zero     <= 1'b0;
      quo          <= 25'd0;
      part         <= 14'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture) begin
            dividend_abs <= din0_abs;
            divisor_abs  <= din1_abs;
            sign0        <= din0[24];
            sign1        <= din1[13];
            div_zero     <= (din1 == 14'd0);
            quo          <= 25'd0;
            part         <= 14'd0;
            cnt          <= 5'd24;
            state        <= S_CALC;
          end
        end
        S_CALC: begin
          quo <= {quo[23:0], step_ge};
          if (step_ge) begin
            part <= part_sub;
          end else begin
            part <= part_sh[13:0];
          end
          if (cnt == 5'd0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_FIX: begin
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sign correction and result registers; results only change in the FIX cycle
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout <= 25'd0;
      rem  <= 14'd0;
    end else if (state == S_FIX) begin
      if (div_zero) begin
        dout <= 25'h1FFFFFF;
        rem  <= 14'd0;
      end else begin
        dout <= (sign0 ^ sign1) ? (25'd0 - quo) : quo;
        rem  <= sign0 ? (14'd0 - part) : part;
      end
    end
  end

endmodule
